// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment receive-side monitor.
//   - segment patterns for digits 0..9 plus the blank pattern (bit0=a .. bit6=g)
//   - monitor FSM state type
//   - counter widths and the error counter saturation value
//   - seg_encode(): digit -> pattern, the same mapping the display driver uses
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

    // Digits above 9 have no glyph and map to blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = SEG_0;
            4'd1:    p = SEG_1;
            4'd2:    p = SEG_2;
            4'd3:    p = SEG_3;
            4'd4:    p = SEG_4;
            4'd5:    p = SEG_5;
            4'd6:    p = SEG_6;
            4'd7:    p = SEG_7;
            4'd8:    p = SEG_8;
            4'd9:    p = SEG_9;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational inverse of the segment encoder.
// Ports:
//   pattern  in  7  segment pattern, bit0=a .. bit6=g
//   digit    out 4  decoded digit 0..9 (0 when pattern is not a digit)
//   is_valid out 1  pattern is one of the ten digit glyphs
//   is_blank out 1  pattern is all segments off
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       is_valid,
    output logic       is_blank
);

    // Search the encoder table so the two directions can never disagree.
    always_comb begin
        digit    = 4'd0;
        is_valid = 1'b0;
        for (int d = 0; d < 10; d++) begin
            if (pattern == seg_encode(4'(d))) begin
                digit    = 4'(d);
                is_valid = 1'b1;
            end
        end
    end

    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_monitor.sv
// -----------------------------------------------------------------------------
// seg7_monitor
// Receive-side checker for a seven-segment display bus. Synchronizes the bus,
// accepts a pattern once it has been stable for STABLE_CYCLES samples, decodes
// it and checks that digits advance 0->1->..->9->0.
//
// Parameters:
//   STABLE_CYCLES  identical synchronized samples needed to accept (2..65535)
// Ports:
//   clk          in  1  clock
//   reset        in  1  synchronous active-high reset
//   segments_in  in  7  segment bus (async to clk), bit0=a .. bit6=g
//   clear_errors in  1  clears error_count
//   digit        out 4  last accepted digit
//   digit_valid  out 1  locked to a valid digit
//   new_digit    out 1  one-cycle pulse per accepted valid digit
//   seq_error    out 1  one-cycle pulse on out-of-sequence digit or bad pattern
//   error_count  out 8  saturating error counter
//
// state | meaning
// ------+----------------------------------------------------------------
// SYNC  | no reference digit; next valid digit is taken without checking
// TRACK | reference digit held in `digit`; each new digit must be digit+1
// -----------------------------------------------------------------------------
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter logic [CNT_W-1:0] STABLE_CYCLES = 16'd1000
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       segments_in,
    input  logic             clear_errors,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             new_digit,
    output logic             seq_error,
    output logic [ERR_W-1:0] error_count
);

    logic [6:0]       s1;
    logic [6:0]       s2;
    logic [6:0]       s2_d;
    logic [6:0]       acc_pattern;
    logic [CNT_W-1:0] stable_cnt;
    mon_state_t       state;

    logic [3:0]       dec_digit;
    logic             dec_valid;
    logic             dec_blank;
    logic [3:0]       next_expected;
    logic             stable_now;
    logic             accept;
    logic             bad_pattern;
    logic             out_of_seq;
    logic             err_event;

    seg7_decode u_decode (
        .pattern  (s2),
        .digit    (dec_digit),
        .is_valid (dec_valid),
        .is_blank (dec_blank)
    );

    assign stable_now    = (s2 == s2_d);
    assign next_expected = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

    // Accept fires on the single cycle the counter steps onto STABLE_CYCLES.
    // Comparing against the last accepted pattern stops a short glitch from
    // re-accepting the pattern that was already on the bus.
    assign accept      = stable_now
                         && (stable_cnt == STABLE_CYCLES - 16'd1)
                         && (s2 != acc_pattern);
    assign bad_pattern = !dec_valid && !dec_blank;
    assign out_of_seq  = dec_valid && (state == TRACK) && (dec_digit != next_expected);
    assign err_event   = accept && (bad_pattern || out_of_seq);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= SEG_BLANK;
            s2          <= SEG_BLANK;
            s2_d        <= SEG_BLANK;
            stable_cnt  <= '0;
            acc_pattern <= SEG_BLANK;
        end else begin
            s1   <= segments_in;
            s2   <= s1;
            s2_d <= s2;
            if (!stable_now) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_CYCLES) begin
                stable_cnt <= stable_cnt + 16'd1;
            end
            if (accept) begin
                acc_pattern <= s2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            new_digit   <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            new_digit <= 1'b0;
            seq_error <= 1'b0;
            if (accept) begin
                if (dec_blank) begin
                    // Display switched off: drop lock quietly, keep last digit.
                    state       <= SYNC;
                    digit_valid <= 1'b0;
                end else if (!dec_valid) begin
                    state       <= SYNC;
                    digit_valid <= 1'b0;
                    seq_error   <= 1'b1;
                end else begin
                    case (state)
                        SYNC: begin
                            state <= TRACK;
                        end
                        TRACK: begin
                            // Stay in TRACK so the check re-anchors on the new digit.
                            seq_error <= out_of_seq;
                        end
                        default: begin
                            state <= SYNC;
                        end
                    endcase
                    digit       <= dec_digit;
                    digit_valid <= 1'b1;
                    new_digit   <= 1'b1;
                end
            end
        end
    end

    // A clear coinciding with an error keeps that error visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_count <= '0;
        end else if (clear_errors) begin
            error_count <= err_event ? ERR_W'(1) : '0;
        end else if (err_event && (error_count != ERR_MAX)) begin
            error_count <= error_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_monitor.sv
module tb_seg7_monitor;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] segments_in = 7'h00;
    logic       clear_errors = 1'b0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       new_digit;
    logic       seq_error;
    logic [7:0] error_count;

    seg7_monitor #(.STABLE_CYCLES(16'(S))) dut (
        .clk          (clk),
        .reset        (reset),
        .segments_in  (segments_in),
        .clear_errors (clear_errors),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .new_digit    (new_digit),
        .seq_error    (seq_error),
        .error_count  (error_count)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    logic rst_at_edge = 1'b1;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    typedef struct {
        int         edge_n;
        logic [3:0] digit;
        logic       dv;
        logic       nd;
        logic       se;
        logic [7:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model, tracked per accepted pattern rather than per cycle.
    bit         m_locked = 0;
    int         m_digit  = 0;
    int         m_cnt    = 0;
    logic [6:0] m_last   = 7'h00;
    logic [6:0] prev_in  = 7'h00;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_digit  = 0;
        m_cnt    = 0;
        m_last   = 7'h00;
        exp_q.delete();
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called at a negedge; the pattern is first sampled on the next posedge
    // and held for `h` posedges. Accept, if any, lands S+3 edges later.
    task automatic drive(input logic [6:0] p, input int h, input bit clr);
        int   n;
        int   e;
        int   d;
        bit   err;
        bit   vis;
        exp_t x;
        n = cyc;
        e = -1;
        segments_in = p;
        prev_in = p;
        if (h >= S + 1 && p != m_last) begin
            e      = n + S + 3;
            m_last = p;
            d      = lookup(p);
            err    = 0;
            vis    = 1;
            x.nd   = 0;
            x.se   = 0;
            if (p == 7'h00) begin
                vis      = m_locked;
                m_locked = 0;
            end else if (d < 0) begin
                err      = 1;
                m_locked = 0;
            end else begin
                err      = m_locked && (d != (m_digit + 1) % 10);
                m_digit  = d;
                m_locked = 1;
                x.nd     = 1;
            end
            if (clr) m_cnt = err ? 1 : 0;
            else if (err && m_cnt < 255) m_cnt++;
            x.edge_n = e;
            x.digit  = 4'(m_digit);
            x.dv     = m_locked;
            x.se     = err;
            x.ec     = 8'(m_cnt);
            if (vis) exp_q.push_back(x);
        end
        for (int i = 0; i < h; i++) begin
            if (clr && e >= 0 && cyc == e - 1) clear_errors = 1'b1;
            @(negedge clk);
            clear_errors = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit"}, int'(digit), 0);
        check({tag, "_digit_valid"}, int'(digit_valid), 0);
        check({tag, "_new_digit"}, int'(new_digit), 0);
        check({tag, "_seq_error"}, int'(seq_error), 0);
        check({tag, "_error_count"}, int'(error_count), 0);
    endtask

    // Monitor: any visible output event pops one expectation.
    logic dv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (!rst_at_edge && (new_digit || seq_error || (dv_prev && !digit_valid))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d digit=%0d dv=%0b nd=%0b se=%0b ec=%0d",
                         cyc, digit, digit_valid, new_digit, seq_error, error_count);
            end else begin
                x = exp_q.pop_front();
                if (x.edge_n != cyc || digit != x.digit || digit_valid != x.dv ||
                    new_digit != x.nd || seq_error != x.se || error_count != x.ec) begin
                    errors++;
                    $display("FAIL event: got cyc=%0d digit=%0d dv=%0b nd=%0b se=%0b ec=%0d expected cyc=%0d digit=%0d dv=%0b nd=%0b se=%0b ec=%0d",
                             cyc, digit, digit_valid, new_digit, seq_error, error_count,
                             x.edge_n, x.digit, x.dv, x.nd, x.se, x.ec);
                end
            end
        end
        dv_prev = digit_valid;
    end

    initial begin
        logic [6:0] p;
        logic [6:0] a;
        logic [6:0] b;
        int r;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_outputs("reset");

        // Lock on 0 then advance to 1.
        drive(7'h3F, 20, 0);
        drive(7'h06, 20, 0);
        // Full sequence through the 9 -> 0 wrap.
        for (int d = 2; d < 10; d++) drive(seg_tab[d], 8, 0);
        drive(7'h3F, 8, 0);

        // Sequence error while tracking, then recovery.
        drive(7'h06, 8, 0);
        drive(7'h5B, 8, 0);
        drive(7'h4F, 8, 0);
        drive(7'h6D, 8, 0);
        drive(7'h7D, 8, 0);

        // Glitch back onto the last accepted pattern, invalid, relock, blank.
        drive(7'h5B, 8, 0);
        drive(7'h7F, 3, 0);
        drive(7'h5B, 10, 0);
        drive(7'h7F, S, 0);
        drive(7'h5B, 10, 0);
        drive(7'h55, 10, 0);
        drive(7'h66, 10, 0);
        drive(7'h00, 10, 0);

        // Randomized mix including holds on both sides of the accept threshold.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       p = seg_tab[(m_digit + 1) % 10];
            else if (r < 7)  p = seg_tab[$urandom_range(0, 9)];
            else if (r == 7) p = 7'h00;
            else             p = 7'($urandom_range(0, 127));
            while (p == prev_in) p = 7'($urandom_range(0, 127));
            drive(p, $urandom_range(1, S + 4), 0);
        end

        // Saturate error_count, then clear in the same cycle as an error.
        a = (prev_in == 7'h55) ? 7'h2A : 7'h55;
        b = a ^ 7'h7F;
        for (int k = 0; k < 256; k++) drive((k % 2 == 0) ? a : b, S + 1, 0);
        drive(a, S + 5, 1);
        drive(7'h3F, 10, 0);
        check("error_count_before_clear", int'(error_count), 1);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        m_cnt = 0;
        check("error_count_after_clear", int'(error_count), 0);

        // Reset inside a stable interval, then relock from scratch.
        drive(7'h06, 10, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_outputs("midreset");
        drive(7'h4F, 10, 0);
        check("relock_digit", int'(digit), 3);
        check("relock_valid", int'(digit_valid), 1);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        check("pending_events", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_monitor.md
# seg7_monitor

Receive-side counterpart of the seven-segment digit driver. Samples a 7-bit segment bus, filters glitches by requiring a pattern to stay stable for a programmable number of cycles, decodes accepted patterns back to digits 0–9, and checks that the sequence advances 0→1→…→9→0. Used as the on-chip loopback checker for the display path, or to monitor an external display bus brought in on the bidirectional pins.

## Interface
Parameters:
- STABLE_CYCLES, default 16'd1000: consecutive identical synchronized samples required to accept a pattern; legal range 2..65535.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is high.
- segments_in  in  7  segment bus, active-high, bit0=a … bit6=g; asynchronous to clk.
- clear_errors  in  1  synchronous clear of error_count.
- digit  out  4  last accepted digit; reset 0.
- digit_valid  out  1  high while locked to a valid digit; reset 0.
- new_digit  out  1  one-cycle pulse on each accepted valid digit; reset 0.
- seq_error  out  1  one-cycle pulse on an out-of-sequence digit or an invalid pattern; reset 0.
- error_count  out  8  saturating error counter; reset 0.

## Operation
- Valid patterns (g..a): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. 0x00 = blank. Every other value is invalid.
- Input path: 2-flop synchronizer (s1, s2), then s2_d holds the previous s2.
- Stability counter (16 bit): cleared to 0 when s2 != s2_d. Otherwise it increments and saturates at STABLE_CYCLES.
- Accept event: the counter transitions from STABLE_CYCLES-1 to STABLE_CYCLES while s2 != the last accepted pattern. There is at most one accept per stable interval. A repeated identical pattern after a glitch shorter than STABLE_CYCLES is not re-accepted.
- FSM states: SYNC (reset state, no reference digit) and TRACK.
- SYNC, valid pattern accepted: digit ← decoded value, digit_valid ← 1, new_digit pulse, go to TRACK. No sequence check is made.
- TRACK, valid pattern accepted: digit updates and new_digit pulses.
  - If decoded ≠ (digit==9 ? 0 : digit+1), seq_error also pulses and error_count increments. State stays TRACK, so the check resynchronizes to the new digit.
- Any state, blank accepted: digit_valid ← 0, go to SYNC. No error is flagged; digit holds its old value.
- Any state, invalid pattern accepted: seq_error pulses, error_count increments, digit_valid ← 0, go to SYNC.
- error_count saturates at 255.
- clear_errors forces error_count to 0. If an error event occurs in the same cycle, error_count becomes 1.
- Reset mid-operation: synchronizer contents, counter, accepted pattern (reset value 0x00 = blank), FSM and all outputs return to their reset values on that edge.

## Timing
- Define edge 1 as the first rising edge that samples a new stable pattern P on segments_in. digit, digit_valid, new_digit and seq_error all update on edge STABLE_CYCLES+3, with no slack. Pulses stay high for exactly one cycle.
- Glitches lasting fewer than STABLE_CYCLES+1 synchronized cycles never cause an accept.
- All outputs are registered. There is no combinational path from input to output.
- Throughput: at most one accept per STABLE_CYCLES+1 cycles.

## Structure
- seg7_pkg holds:
  - the ten segment pattern constants and SEG_BLANK;
  - the FSM state enum {SYNC, TRACK};
  - the width constants for the counter (16) and error_count (8).
- Sub-module seg7_decode is purely combinational and is the inverse of the existing segment encoder. Inputs: 7-bit pattern. Outputs: digit[3:0], is_valid, is_blank. It is instantiated once on s2.
- Synchronizer, stability counter and FSM live in seg7_monitor.

## Test plan
- STABLE_CYCLES=4. After reset, drive 0x3F then 0x06, each held for 20 cycles → new_digit pulses on edge 7 after each change; digit=0 then 1; digit_valid=1; error_count=0.
- Sequence 0→…→9→0 (0x6F then 0x3F) → 11 new_digit pulses, no seq_error, digit wraps from 9 to 0.
- In TRACK at digit=3, drive 0x6D (5) → seq_error pulse, error_count=1, digit=5. Then 0x7D (6) → no error.
- In TRACK at digit=2, drive a 3-cycle glitch of 0x7F, then return to 0x5B → no new_digit, no error, digit stays 2. Then drive 0x55 (invalid) stable → seq_error, digit_valid=0, SYNC. Then 0x66 → lock with digit=4 and no error.
- Force 256 invalid accepts → error_count=255. Then clear_errors together with one more error event → 1. Assert reset in the middle of a stable interval → all outputs 0, and the next accepted valid pattern locks without error.
